// File: rtl/mem_line_arbiter_pkg.sv
// Shared definitions for the two-port line-memory arbiter.
// Contents:
//   arb_state_t : arbiter FSM state encoding (IDLE / BUSY)
//   N_PORTS     : number of requesting cache controllers
//   lw()        : line bus width in bits for a given LINE_ADDR_LEN
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int N_PORTS = 2;

    // A line holds 2^line_addr_len 32-bit words.
    function automatic int lw(input int line_addr_len);
        return 32 << line_addr_len;
    endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Bus bundle between two cache controllers, the arbiter and main memory.
// Handshake (both sides): a request (req_rd/req_wr per port, mem_rd_req/
// mem_wr_req toward memory) is a level held, together with its address and
// write line, until the matching one-cycle grant pulse (gnt[p] / mem_gnt).
// The grant cycle is the completion cycle; read data (rline / mem_rline) is
// valid only in that cycle. The requester drops or replaces its request
// after the edge that ends the grant cycle.
// Modports:
//   slave  : arbiter view (consumes cache requests and mem_gnt/mem_rline)
//   master : environment view (caches + main memory)
interface mem_line_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 7
);
    localparam int LW = lw(LINE_ADDR_LEN);

    // cache side
    logic [N_PORTS-1:0] req_rd;
    logic [N_PORTS-1:0] req_wr;
    logic [ADDR_LEN-1:0] req_addr0;
    logic [ADDR_LEN-1:0] req_addr1;
    logic [LW-1:0]       req_wline0;
    logic [LW-1:0]       req_wline1;
    logic [N_PORTS-1:0] gnt;
    logic [LW-1:0]       rline;

    // memory side
    logic                mem_rd_req;
    logic                mem_wr_req;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [LW-1:0]       mem_wline;
    logic                mem_gnt;
    logic [LW-1:0]       mem_rline;

    modport slave (
        input  req_rd, req_wr, req_addr0, req_addr1, req_wline0, req_wline1,
        input  mem_gnt, mem_rline,
        output gnt, rline, mem_rd_req, mem_wr_req, mem_addr, mem_wline
    );

    modport master (
        output req_rd, req_wr, req_addr0, req_addr1, req_wline0, req_wline1,
        output mem_gnt, mem_rline,
        input  gnt, rline, mem_rd_req, mem_wr_req, mem_addr, mem_wline
    );

endinterface

// File: rtl/mem_line_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   act[1:0]  in  per-port pending request
//   last      in  port that owned the previous transaction
//   lock      in  write-back lock is armed
//   lock_port in  port holding the lock
//   sel       out selected port (meaningful when valid)
//   valid     out at least one port is pending
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] act,
    input  logic               last,
    input  logic               lock,
    input  logic               lock_port,
    output logic               sel,
    output logic               valid
);

    always_comb begin
        valid = |act;
        sel   = last;
        if (lock && act[lock_port]) begin
            sel = lock_port;
        end else if (act == 2'b01) begin
            sel = 1'b0;
        end else if (act == 2'b10) begin
            sel = 1'b1;
        end else if (act == 2'b11) begin
            // tie: hand the line to whoever did not go last
            sel = ~last;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Two-port line-memory arbiter (port 0 = I-cache, port 1 = D-cache) in front
// of a single line-granular main memory. Round-robin between ports, with an
// optional lock that keeps a dirty-line write-back and the same port's
// refill read together.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache request/grant bundle plus main-memory request bundle
//   owner      : current/last owning port
//   busy       : high in BUSY; together with IDLE this is the full FSM state
// Parameters:
//   LOCK_SWAP  : 1 = a granted write keeps ownership for that port's next read
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LOCK_SWAP = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    mem_line_arbiter_if.slave bus,
    output logic              owner,
    output logic              busy
);

    arb_state_t state, state_nxt;
    logic owner_nxt;
    logic lock, lock_nxt;

    logic [N_PORTS-1:0] act;
    logic pick_sel, pick_valid;
    logic own_rd, own_wr;

    assign act    = bus.req_rd | bus.req_wr;
    assign own_rd = bus.req_rd[owner];
    assign own_wr = bus.req_wr[owner];

    // The lock always belongs to the port whose write was just granted,
    // which is the current owner.
    rr_pick2 u_pick (
        .act       (act),
        .last      (owner),
        .lock      (lock),
        .lock_port (owner),
        .sel       (pick_sel),
        .valid     (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            owner <= 1'b1;   // port 0 wins the first tie
            lock  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            lock  <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        lock_nxt       = lock;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wline  = '0;
        bus.gnt        = '0;
        case (state)
            ARB_IDLE: begin
                // the lock only survives into this one arbitration cycle
                lock_nxt = 1'b0;
                if (pick_valid) begin
                    owner_nxt = pick_sel;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // write wins if a port illegally raises both
                bus.mem_rd_req = own_rd & ~own_wr;
                bus.mem_wr_req = own_wr;
                bus.mem_addr   = owner ? bus.req_addr1  : bus.req_addr0;
                bus.mem_wline  = owner ? bus.req_wline1 : bus.req_wline0;
                if (!(own_rd || own_wr)) begin
                    // requester withdrew before completion: abort, no grant
                    state_nxt = ARB_IDLE;
                    lock_nxt  = 1'b0;
                end else if (bus.mem_gnt) begin
                    bus.gnt[owner] = 1'b1;
                    state_nxt      = ARB_IDLE;
                    lock_nxt       = (LOCK_SWAP != 0) && own_wr;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign bus.rline = bus.mem_rline;
    assign busy      = (state == ARB_BUSY);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter. Two instances: g_dut[0] with LOCK_SWAP=1 and
// g_dut[1] with LOCK_SWAP=0, each with its own 5-cycle main-memory model.
module tb_mem_line_arbiter;
    import mem_arb_pkg::*;

    localparam int LAL = 3;
    localparam int AL  = 7;
    localparam int LW  = lw(LAL);
    localparam int LAT = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- per-instance, per-port stimulus ----------------
    logic            rd_v   [2][2];
    logic            wr_v   [2][2];
    logic [AL-1:0]   addr_v [2][2];
    logic [LW-1:0]   wline_v[2][2];
    logic            stray_v[2];

    logic [1:0]      gnt_v      [2];
    logic [LW-1:0]   rline_v    [2];
    logic            mem_rd_v   [2];
    logic            mem_wr_v   [2];
    logic [AL-1:0]   mem_addr_v [2];
    logic [LW-1:0]   mem_wline_v[2];
    logic            owner_v    [2];
    logic            busy_v     [2];

    function automatic logic [LW-1:0] line_pat(input logic [AL-1:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[32*k +: 32] = {16'hCAFE, 1'b0, a, 8'(k)};
        return l;
    endfunction

    function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[32*k +: 32] = seed + 32'(k);
        return l;
    endfunction

    mem_line_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus[2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [2:0]    cnt;
        logic          model_gnt;
        logic [LW-1:0] wr_m [128];
        logic          wr_ok[128];

        assign bus[g].req_rd     = {rd_v[g][1], rd_v[g][0]};
        assign bus[g].req_wr     = {wr_v[g][1], wr_v[g][0]};
        assign bus[g].req_addr0  = addr_v[g][0];
        assign bus[g].req_addr1  = addr_v[g][1];
        assign bus[g].req_wline0 = wline_v[g][0];
        assign bus[g].req_wline1 = wline_v[g][1];

        // memory answers in the 5th cycle a request is held
        assign model_gnt = (bus[g].mem_rd_req || bus[g].mem_wr_req) && (cnt == 3'(LAT - 1));
        assign bus[g].mem_gnt   = model_gnt | stray_v[g];
        assign bus[g].mem_rline = wr_ok[bus[g].mem_addr] ? wr_m[bus[g].mem_addr]
                                                         : line_pat(bus[g].mem_addr);

        always @(posedge clk) begin
            if (!(bus[g].mem_rd_req || bus[g].mem_wr_req) || model_gnt) cnt <= 3'd0;
            else cnt <= cnt + 3'd1;
            if (!rst_n) begin
                for (int a = 0; a < 128; a++) wr_ok[a] <= 1'b0;
            end else if (bus[g].mem_gnt && bus[g].mem_wr_req) begin
                wr_m[bus[g].mem_addr]  <= bus[g].mem_wline;
                wr_ok[bus[g].mem_addr] <= 1'b1;
            end
        end

        assign gnt_v[g]       = bus[g].gnt;
        assign rline_v[g]     = bus[g].rline;
        assign mem_rd_v[g]    = bus[g].mem_rd_req;
        assign mem_wr_v[g]    = bus[g].mem_wr_req;
        assign mem_addr_v[g]  = bus[g].mem_addr;
        assign mem_wline_v[g] = bus[g].mem_wline;

        mem_line_arbiter #(.LOCK_SWAP((g == 0) ? 1 : 0)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g]),
            .owner (owner_v[g]),
            .busy  (busy_v[g])
        );
    end

    // illegal rd+wr on one port
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++)
            for (int p = 0; p < 2; p++)
                if (rst_n) assert (!(rd_v[g][p] && wr_v[g][p]))
                    else $error("illegal simultaneous rd and wr, dut %0d port %0d", g, p);
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // grant log: key = {port, was_write, addr}
    typedef struct { int dut; logic [8:0] key; int cyc; logic own; } gl_t;
    gl_t glog[$];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_n && gnt_v[g] != 2'b00) begin
                gl_t e;
                e.dut = g;
                e.key = {gnt_v[g][1], mem_wr_v[g], mem_addr_v[g]};
                e.cyc = cyc;
                e.own = owner_v[g];
                glog.push_back(e);
            end
        end
    end

    // compare one instance's grant log against an expected queue
    task automatic check_order(input string name, input int g, input logic [8:0] exp_in[$],
                               input int gap);
        logic [8:0] exp_q[$];
        gl_t got_q[$];
        exp_q = exp_in;
        foreach (glog[i]) if (glog[i].dut == g) got_q.push_back(glog[i]);
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check({name, "_grant"}, 64'(got_q[i].key), 64'(exp_q[i]));
                if (i > 0) check({name, "_gap"}, 64'(got_q[i].cyc - got_q[i-1].cyc), 64'(gap));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    typedef struct { logic rd; logic wr; logic [AL-1:0] addr; logic [LW-1:0] wline; } op_t;
    op_t script[2][2][4];

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // entered and left at posedge+1; holds each op until its gnt
    task automatic port_proc(input int g, input int p, input int n, input int delay);
        int w;
        for (int d = 0; d < delay; d++) begin @(posedge clk); #1; end
        for (int i = 0; i < n; i++) begin
            rd_v[g][p]    = script[g][p][i].rd;
            wr_v[g][p]    = script[g][p][i].wr;
            addr_v[g][p]  = script[g][p][i].addr;
            wline_v[g][p] = script[g][p][i].wline;
            w = 0;
            @(negedge clk);
            while (!gnt_v[g][p] && w < 200) begin @(negedge clk); w++; end
            check("port_gnt_timeout", 64'(gnt_v[g][p]), 64'(1));
            @(posedge clk);
            #1;
        end
        rd_v[g][p] = 1'b0;
        wr_v[g][p] = 1'b0;
    endtask

    // ---------------- single-transaction vector table ----------------
    typedef struct {
        logic          p;
        logic          rd;
        logic          wr;
        logic [AL-1:0] addr;
        logic [LW-1:0] wline;
        logic          exp_mem_rd;
        logic          exp_mem_wr;
        logic          chk_line;
        logic [LW-1:0] exp_line;
    } vec_t;

    vec_t vecs[7];
    logic [8:0] eq[$];

    initial begin : main
        int n;
        for (int g = 0; g < 2; g++) begin
            stray_v[g] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rd_v[g][p] = 1'b0; wr_v[g][p] = 1'b0;
                addr_v[g][p] = '0; wline_v[g][p] = '0;
            end
        end

        vecs[0] = '{1'b0, 1'b1, 1'b0, 7'h12, '0,                   1'b1, 1'b0, 1'b1, line_pat(7'h12)};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 7'h40, '0,                   1'b1, 1'b0, 1'b1, line_pat(7'h40)};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 7'h22, mk_line(32'h1111_0000), 1'b0, 1'b1, 1'b0, '0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 7'h7F, mk_line(32'h7F7F_0000), 1'b0, 1'b1, 1'b0, '0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 7'h7F, '0,                   1'b1, 1'b0, 1'b1, mk_line(32'h7F7F_0000)};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 7'h00, '0,                   1'b1, 1'b0, 1'b1, line_pat(7'h00)};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 7'h22, '0,                   1'b1, 1'b0, 1'b1, mk_line(32'h1111_0000)};

        // ---- reset state ----
        do_reset();
        check("rst_owner", 64'(owner_v[0]), 64'(1));
        check("rst_busy", 64'(busy_v[0]), 64'(0));
        check("rst_gnt", 64'(gnt_v[0]), 64'(0));
        check("rst_memreq", 64'({mem_rd_v[0], mem_wr_v[0]}), 64'(0));
        check("rst_memaddr", 64'(mem_addr_v[0]), 64'(0));
        check_line("rst_memwline", mem_wline_v[0], '0);

        // ---- table: one transaction at a time on instance 0 ----
        for (int i = 0; i < 7; i++) begin
            rd_v[0][vecs[i].p]    = vecs[i].rd;
            wr_v[0][vecs[i].p]    = vecs[i].wr;
            addr_v[0][vecs[i].p]  = vecs[i].addr;
            wline_v[0][vecs[i].p] = vecs[i].wline;
            @(negedge clk);   // arbitration cycle
            check("v_idle_busy", 64'(busy_v[0]), 64'(0));
            check("v_idle_memreq", 64'({mem_rd_v[0], mem_wr_v[0]}), 64'(0));
            check("v_idle_addr", 64'(mem_addr_v[0]), 64'(0));
            @(negedge clk);   // first BUSY cycle
            check("v_busy", 64'(busy_v[0]), 64'(1));
            check("v_owner", 64'(owner_v[0]), 64'(vecs[i].p));
            check("v_mem_rd", 64'(mem_rd_v[0]), 64'(vecs[i].exp_mem_rd));
            check("v_mem_wr", 64'(mem_wr_v[0]), 64'(vecs[i].exp_mem_wr));
            check("v_mem_addr", 64'(mem_addr_v[0]), 64'(vecs[i].addr));
            check_line("v_mem_wline", mem_wline_v[0], vecs[i].wline);
            n = 1;
            while (gnt_v[0] == 2'b00 && n < 50) begin @(negedge clk); n++; end
            check("v_latency", 64'(n), 64'(LAT));
            check("v_gnt", 64'(gnt_v[0]), 64'(2'b01 << vecs[i].p));
            if (vecs[i].chk_line) check_line("v_rline", rline_v[0], vecs[i].exp_line);
            @(posedge clk);
            #1;
            rd_v[0][vecs[i].p] = 1'b0;
            wr_v[0][vecs[i].p] = 1'b0;
            @(negedge clk);
            check("v_after_busy", 64'(busy_v[0]), 64'(0));
            check("v_after_gnt", 64'(gnt_v[0]), 64'(0));
            @(posedge clk);
            #1;
        end

        // ---- tie round-robin from reset ----
        do_reset();
        glog.delete();
        for (int k = 0; k < 2; k++) begin
            script[0][0][k] = '{1'b1, 1'b0, 7'h01, '0};
            script[0][1][k] = '{1'b1, 1'b0, 7'h40, '0};
        end
        fork
            port_proc(0, 0, 2, 0);
            port_proc(0, 1, 2, 0);
        join
        eq = '{{1'b0, 1'b0, 7'h01}, {1'b1, 1'b0, 7'h40}, {1'b0, 1'b0, 7'h01}, {1'b1, 1'b0, 7'h40}};
        check_order("tie", 0, eq, LAT + 1);
        foreach (glog[i]) check("tie_owner", 64'(glog[i].own), 64'(glog[i].key[8]));

        // ---- write-back lock on both instances ----
        do_reset();
        glog.delete();
        for (int g = 0; g < 2; g++) begin
            script[g][1][0] = '{1'b0, 1'b1, 7'h33, mk_line(32'h3333_A000)};
            script[g][1][1] = '{1'b1, 1'b0, 7'h05, '0};
            script[g][0][0] = '{1'b1, 1'b0, 7'h10, '0};
        end
        fork
            port_proc(0, 1, 2, 0);
            port_proc(0, 0, 1, 1);
            port_proc(1, 1, 2, 0);
            port_proc(1, 0, 1, 1);
        join
        eq = '{{1'b1, 1'b1, 7'h33}, {1'b1, 1'b0, 7'h05}, {1'b0, 1'b0, 7'h10}};
        check_order("lock_on", 0, eq, LAT + 1);
        eq = '{{1'b1, 1'b1, 7'h33}, {1'b0, 1'b0, 7'h10}, {1'b1, 1'b0, 7'h05}};
        check_order("lock_off", 1, eq, LAT + 1);
        check("lock_on_written", 64'(g_dut[0].wr_ok[7'h33]), 64'(1));
        check_line("lock_on_wline", g_dut[0].wr_m[7'h33], mk_line(32'h3333_A000));
        check_line("lock_off_wline", g_dut[1].wr_m[7'h33], mk_line(32'h3333_A000));

        // ---- reset in the middle of a read ----
        @(posedge clk);
        #1;
        rd_v[0][0] = 1'b1;
        addr_v[0][0] = 7'h12;
        repeat (4) @(negedge clk);   // arbitration cycle + BUSY cycles 1..3
        check("mid_rd_before", 64'(mem_rd_v[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_memreq_drop", 64'({mem_rd_v[0], mem_wr_v[0]}), 64'(0));
        check("mid_busy_drop", 64'(busy_v[0]), 64'(0));
        check("mid_gnt", 64'(gnt_v[0]), 64'(0));
        rd_v[0][0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_gnt_hold", 64'(gnt_v[0]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_owner", 64'(owner_v[0]), 64'(1));
        check("mid_idle", 64'(busy_v[0]), 64'(0));

        // ---- abort, then stray memory grant while idle ----
        @(posedge clk);
        #1;
        rd_v[0][0] = 1'b1;
        addr_v[0][0] = 7'h12;
        @(negedge clk);
        @(negedge clk);
        check("ab_busy", 64'(busy_v[0]), 64'(1));
        @(posedge clk);
        #1;
        rd_v[0][0] = 1'b0;
        #1;
        check("ab_memreq_drop", 64'(mem_rd_v[0]), 64'(0));
        check("ab_gnt", 64'(gnt_v[0]), 64'(0));
        @(negedge clk);
        @(negedge clk);
        check("ab_idle", 64'(busy_v[0]), 64'(0));
        check("ab_owner", 64'(owner_v[0]), 64'(0));
        check("ab_gnt_after", 64'(gnt_v[0]), 64'(0));
        @(posedge clk);
        #1;
        stray_v[0] = 1'b1;
        #1;
        check("stray_gnt", 64'(gnt_v[0]), 64'(0));
        @(posedge clk);
        #1;
        stray_v[0] = 1'b0;
        @(negedge clk);
        check("stray_idle", 64'(busy_v[0]), 64'(0));
        check("stray_memreq", 64'({mem_rd_v[0], mem_wr_v[0]}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Two-requester arbiter that shares one line-granular main memory between two cache controllers (port 0 = I-cache, port 1 = D-cache).
- Uses the same level-request / single-cycle-gnt handshake on both sides.
- Round-robin fairness, with an optional write-back lock: a dirty-line swap-out followed by its refill read completes without losing ownership.
- Sits between the caches and main_mem.

Parameters:
- LINE_ADDR_LEN, 3: words per line = 2^LINE_ADDR_LEN; line bus width LW = 32 << LINE_ADDR_LEN.
- ADDR_LEN, 7: line address width into main memory.
- LOCK_SWAP, 1: 1 = ownership held from a granted write into the same port's immediately following read.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_rd[1:0]  in  2  per-port line read request; level, held until that port's gnt
- req_wr[1:0]  in  2  per-port line write request; level, held until gnt
- req_addr0, req_addr1  in  ADDR_LEN each  line address per port
- req_wline0, req_wline1  in  LW each  write line per port (flattened, word 0 in bits [31:0])
- gnt[1:0]  out  2  one-cycle completion pulse to the owning port
- rline  out  LW  read line, valid when gnt is high (broadcast; only the granted port samples)
- mem_rd_req, mem_wr_req  out  1 each  to main memory
- mem_addr  out  ADDR_LEN  to main memory
- mem_wline  out  LW  to main memory
- mem_gnt  in  1  from main memory
- mem_rline  in  LW  from main memory
- owner  out  1  current/last owner port
- busy  out  1  high in BUSY state

Behaviour:
- Reset (rst_n low, async): state=IDLE, owner=1 (so port 0 wins first tie), lock=0, all mem_* requests 0, gnt=0, busy=0. mem_addr and mem_wline are 0 while not BUSY. Reset mid-transaction drops mem requests immediately; no gnt is produced.
- Port request pending: act[p] = req_rd[p] | req_wr[p].
- Both rd and wr asserted on one port is illegal. The arbiter forwards it as a write (wr priority) and a bench assertion flags it.
- FSM states: IDLE, BUSY.
- IDLE:
  - Lock set and the locked port requesting: select it.
  - Otherwise, one port active: select it.
  - Otherwise, both active: select ~owner (round-robin).
  - On a selection: owner<=sel, state<=BUSY next edge.
  - Nothing active: stay IDLE, lock<=0.
- BUSY:
  - mem_rd_req = req_rd[owner] & ~req_wr[owner]; mem_wr_req = req_wr[owner].
  - mem_addr = selected port's address; mem_wline = selected port's write line. These are combinational pass-through, so the requester must hold them stable.
  - gnt[owner] = mem_gnt (combinational, same cycle); rline = mem_rline.
  - On mem_gnt: state<=IDLE; lock <= LOCK_SWAP & mem_wr_req.
- Abort: owner drops both requests in BUSY before mem_gnt. mem requests fall the same cycle, state<=IDLE, lock<=0, no gnt.
- A stray mem_gnt in IDLE is ignored (no gnt output).
- Latency: request first visible at edge N → mem request asserted in cycle N+1. Arbiter overhead is 1 cycle per transaction, plus memory latency.
- Lock:
  - Lock is consumed in the first IDLE cycle.
  - Locked port not requesting in that cycle: lock clears and normal arbitration applies the same cycle.
  - Locked write-then-read does not flip owner, so the other port wins the next tie.
- Fairness bound: with both ports continuously requesting, neither port waits more than one foreign transaction (two with lock: write-back plus refill).

Decomposition:
- Shared package mem_arb_pkg: typedef enum {ARB_IDLE, ARB_BUSY} arb_state_t; localparam N_PORTS=2; line-width function lw(LINE_ADDR_LEN).
- One natural sub-module: rr_pick2 (combinational 2-way round-robin picker: inputs act, last, lock, lock_port; output sel, valid). Remainder is single-module RTL.

Test Plan:
- Single read: port 0 req_rd, addr 7'h12; memory model with 5-cycle gnt → mem_rd_req high from cycle 1; gnt[0] in the same cycle as mem_gnt; rline equals the model's line for 0x12; mem_addr=0x12; port 1 never granted.
- Tie round-robin: both ports read continuously from reset (0x01 / 0x40) → grant order 0,1,0,1 over 4 transactions; owner toggles; busy drops exactly 1 cycle between transactions.
- Write-back lock (LOCK_SWAP=1): port 1 writes 0x33 then reads 0x05 while port 0 reads 0x10 throughout → port 1 write and read granted back-to-back; port 0 served third; model shows 0x33 written with req_wline1.
- Lock disabled (LOCK_SWAP=0), same stimulus → order: port 1 write, port 0 read, port 1 read.
- Reset mid-op: assert rst_n=0 in BUSY two cycles before mem_gnt → mem_rd_req/mem_wr_req fall asynchronously; no gnt; after release, owner=1 and state=IDLE.
- Abort plus stray gnt: port 0 drops req_rd in BUSY → IDLE next cycle, no gnt[0]; mem_gnt pulsed in IDLE → gnt stays 2'b00.
